// File: rtl/pad_reader_if.sv
// Signal bundle between pad_reader and its user: control, serial pad lines and results.
// Carries the per-pad `changed` strobe only when PAD_CHANGE_DETECT_EN is defined.
interface pad_reader_if #(
  parameter int NUM_PADS = 2,
  parameter int NUM_BITS = 8
);
  logic                         en;
  logic                         start;
  logic [NUM_PADS-1:0]          ser_data;
  logic                         ser_latch;
  logic                         ser_clk;
  logic [NUM_PADS*NUM_BITS-1:0] buttons;
  logic                         valid;
  logic                         busy;
`ifdef PAD_CHANGE_DETECT_EN
  logic [NUM_PADS-1:0]          changed;

  modport master (
    output en, start, ser_data,
    input  ser_latch, ser_clk, buttons, valid, busy, changed
  );
  modport slave (
    input  en, start, ser_data,
    output ser_latch, ser_clk, buttons, valid, busy, changed
  );
`else
  modport master (
    output en, start, ser_data,
    input  ser_latch, ser_clk, buttons, valid, busy
  );
  modport slave (
    input  en, start, ser_data,
    output ser_latch, ser_clk, buttons, valid, busy
  );
`endif
endinterface

// File: rtl/pad_reader.sv
// NES/SNES style serial pad reader: latches all pads, shifts NUM_BITS bits out of each in parallel.
// Optional feature macro PAD_CHANGE_DETECT_EN adds a per-pad `changed` strobe alongside valid.
module pad_reader #(
  parameter int NUM_PADS = 2,
  parameter int NUM_BITS = 8,
  parameter int CLK_DIV  = 300
) (
  input  logic        clk,
  input  logic        reset,
  pad_reader_if.slave bus
);
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int IDX_W = $clog2(NUM_BITS);
  localparam logic [DIV_W-1:0] PHASE_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SHIFT_LO, S_SHIFT_HI, S_DONE
  } state_t;

  state_t                       r_state;
  logic [DIV_W-1:0]             r_div;
  logic [IDX_W-1:0]             r_idx;
  logic                         r_ser_latch;
  logic                         r_ser_clk;
  logic [NUM_PADS*NUM_BITS-1:0] r_buttons;
  logic                         r_valid;
  logic                         r_busy;
  logic                         w_sample_en;
  logic [NUM_PADS*NUM_BITS-1:0] w_samples_inv;
`ifdef PAD_CHANGE_DETECT_EN
  logic [NUM_PADS-1:0]          r_changed;
  logic [NUM_PADS-1:0]          w_slice_diff;
`endif

  // Sample on the last cycle of the low half, just before the pad sees the rising shift edge.
  assign w_sample_en = (r_state == S_SHIFT_LO) && (r_div == PHASE_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      logic                r_sync1;
      logic                r_sync2;
      logic [NUM_BITS-1:0] r_shift;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync1 <= 1'b1;
          r_sync2 <= 1'b1;
          r_shift <= '0;
        end else begin
          r_sync1 <= bus.ser_data[gi];
          r_sync2 <= r_sync1;
          if (w_sample_en) begin
            r_shift[r_idx] <= r_sync2;
          end
        end
      end

      // Lines are active-low, so a captured 0 means the button is pressed.
      assign w_samples_inv[gi*NUM_BITS +: NUM_BITS] = ~r_shift;
`ifdef PAD_CHANGE_DETECT_EN
      assign w_slice_diff[gi] = (w_samples_inv[gi*NUM_BITS +: NUM_BITS]
                                 != r_buttons[gi*NUM_BITS +: NUM_BITS]);
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_idx       <= '0;
      r_ser_latch <= 1'b0;
      r_ser_clk   <= 1'b1;
      r_buttons   <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && bus.en) begin
            r_state     <= S_LATCH;
            r_div       <= '0;
            r_idx       <= '0;
            r_ser_latch <= 1'b1;
            r_ser_clk   <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_LATCH: begin
          if (r_div == LATCH_LAST) begin
            r_state     <= S_SHIFT_LO;
            r_div       <= '0;
            r_ser_latch <= 1'b0;
            r_ser_clk   <= 1'b0;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_SHIFT_LO: begin
          if (r_div == PHASE_LAST) begin
            r_state   <= S_SHIFT_HI;
            r_div     <= '0;
            r_ser_clk <= 1'b1;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_SHIFT_HI: begin
          if (r_div == PHASE_LAST) begin
            r_div <= '0;
            if (r_idx == IDX_LAST) begin
              r_state <= S_DONE;
            end else begin
              r_idx     <= r_idx + IDX_W'(1);
              r_state   <= S_SHIFT_LO;
              r_ser_clk <= 1'b0;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_buttons <= w_samples_inv;
          r_valid   <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PAD_CHANGE_DETECT_EN
  // Compared against the held buttons, which read as zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_changed <= '0;
    end else if (r_state == S_DONE) begin
      r_changed <= w_slice_diff;
    end else begin
      r_changed <= '0;
    end
  end

  assign bus.changed = r_changed;
`endif

  assign bus.ser_latch = r_ser_latch;
  assign bus.ser_clk   = r_ser_clk;
  assign bus.buttons   = r_buttons;
  assign bus.valid     = r_valid;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_pad_reader.sv
// Randomized scoreboard bench for pad_reader driven by a behavioural shift-register pad model.
// Also reads a one-pad 16-bit instance; `changed` is checked when PAD_CHANGE_DETECT_EN is defined.
`timescale 1ns/1ps
module tb_pad_reader;
  localparam int NP   = 2;
  localparam int NB   = 8;
  localparam int CD   = 4;
  localparam int LAT  = (2 + 2*NB) * CD + 1;
  localparam int NB2  = 16;
  localparam int LAT2 = (2 + 2*NB2) * CD + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pad_reader_if #(.NUM_PADS(NP), .NUM_BITS(NB))  bus  ();
  pad_reader_if #(.NUM_PADS(1),  .NUM_BITS(NB2)) bus2 ();

  pad_reader #(.NUM_PADS(NP), .NUM_BITS(NB), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  pad_reader #(.NUM_PADS(1), .NUM_BITS(NB2), .CLK_DIV(CD)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  // Pad model: latch loads bit 0, each rising shift clock advances one bit; lines are active-low.
  logic [NP*NB-1:0] pad_word = '0;
  int pad_pos = 0;
  always @(posedge bus.ser_clk or posedge bus.ser_latch) begin
    if (bus.ser_latch) pad_pos <= 0;
    else               pad_pos <= pad_pos + 1;
  end
  always_comb begin
    bus.ser_data = '1;
    for (int p = 0; p < NP; p++)
      if (pad_pos >= 0 && pad_pos < NB) bus.ser_data[p] = ~pad_word[p*NB + pad_pos];
  end

  typedef struct {
    logic [NP*NB-1:0] buttons;
    logic [NP-1:0]    changed;
    int               due;
  } exp_t;
  exp_t exp_q[$];
  logic [NP*NB-1:0] model_prev = '0;

  int checks = 0;
  int errors = 0;
  int read_no = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push_expect(input int accept_cyc, input logic [NP*NB-1:0] pressed);
    exp_t e;
    e.buttons = pressed;
    e.due     = accept_cyc + LAT;
    for (int p = 0; p < NP; p++)
      e.changed[p] = (pressed[p*NB +: NB] != model_prev[p*NB +: NB]);
    model_prev = pressed;
    exp_q.push_back(e);
  endfunction

  // Monitor: protocol counters plus scoreboard pop on every valid pulse.
  int latch_cyc = 0, clk_low_cyc = 0, clk_falls = 0;
  logic prev_sclk = 1'b1;
  always @(negedge clk) begin
    if (reset) begin
      latch_cyc = 0; clk_low_cyc = 0; clk_falls = 0; prev_sclk = 1'b1;
    end else begin
      if (bus.ser_latch) latch_cyc++;
      if (!bus.ser_clk) clk_low_cyc++;
      if (prev_sclk && !bus.ser_clk) clk_falls++;
      prev_sclk = bus.ser_clk;
      if (bus.valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(bus.valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          read_no++;
          $display("read %0d: buttons=%h expected=%h cycle=%0d due=%0d",
                   read_no, bus.buttons, e.buttons, cyc, e.due);
          check("buttons", 64'(bus.buttons), 64'(e.buttons));
          check("latency", 64'(cyc), 64'(e.due));
          check("latch_cycles", 64'(latch_cyc), 64'(2*CD));
          check("sclk_low_pulses", 64'(clk_falls), 64'(NB));
          check("sclk_low_cycles", 64'(clk_low_cyc), 64'(NB*CD));
`ifdef PAD_CHANGE_DETECT_EN
          check("changed", 64'(bus.changed), 64'(e.changed));
`endif
        end
        latch_cyc = 0; clk_low_cyc = 0; clk_falls = 0;
      end
    end
  end

  task automatic issue_read(input logic [NP*NB-1:0] pressed, input bit drop_en, input bit expect_it);
    pad_word  = pressed;
    bus.en    = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (expect_it) push_expect(cyc, pressed);
    bus.start = 1'b0;
    if (drop_en) bus.en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    int a, n;
    logic [NP*NB-1:0] pat;
    bus.en = 1'b0;  bus.start = 1'b0;
    bus2.en = 1'b0; bus2.start = 1'b0; bus2.ser_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ser_latch", 64'(bus.ser_latch), 64'd0);
    check("rst_ser_clk",   64'(bus.ser_clk),   64'd1);
    check("rst_buttons",   64'(bus.buttons),   64'd0);
    check("rst_valid",     64'(bus.valid),     64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reference read: A, Select, Right on pad 0; a start pulse mid-read must be ignored.
    issue_read(16'h0085, 1'b0, 1'b1);
    repeat (20) @(posedge clk); #1;
    check("busy_mid_read", 64'(bus.busy), 64'd1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_drain(200);
    repeat (90) @(posedge clk); #1;

    // One 16-bit pad with every line held low.
    bus2.en = 1'b1; bus2.start = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    bus2.start = 1'b0;
    n = 0;
    while (!bus2.valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("snes_latency", 64'(cyc - a), 64'(LAT2));
    check("snes_buttons", 64'(bus2.buttons), 64'hFFFF);
    @(posedge clk); #1;

    // Random patterns, half of them with en dropped mid-read.
    for (int i = 0; i < 8; i++) begin
      pat = (NP*NB)'($urandom);
      issue_read(pat, 1'($urandom_range(0, 1)), 1'b1);
      wait_drain(300);
    end

    // start held high: three back-to-back reads.
    pat = (NP*NB)'($urandom) | 16'h0101;
    pad_word = pat; bus.en = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    for (int k = 0; k < 3; k++) push_expect(a + k*(LAT + 1), pat);
    while (cyc < a + 2*(LAT + 1) + 12) @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_drain(400);
    repeat (100) @(posedge clk); #1;

    // Two identical reads, then pad 1 changes.
    pat = 16'h3C5A;
    issue_read(pat, 1'b0, 1'b1);          wait_drain(300);
    issue_read(pat, 1'b0, 1'b1);          wait_drain(300);
    issue_read(pat ^ 16'h1000, 1'b0, 1'b1); wait_drain(300);

    // en low with start high: nothing may start.
    bus.en = 1'b0; bus.start = 1'b1;
    repeat (50) @(posedge clk); #1;
    check("en0_latch_cycles", 64'(latch_cyc), 64'd0);
    check("en0_busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;

    // Reset during the fourth low shift phase abandons the read.
    issue_read(16'hA5C3, 1'b0, 1'b0);
    a = cyc;
    while (cyc < a + 33) @(posedge clk);
    #1;
    check("pre_rst_sclk", 64'(bus.ser_clk), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_ser_clk",   64'(bus.ser_clk),   64'd1);
    check("abort_ser_latch", 64'(bus.ser_latch), 64'd0);
    check("abort_busy",      64'(bus.busy),      64'd0);
    check("abort_buttons",   64'(bus.buttons),   64'd0);
    check("abort_valid",     64'(bus.valid),     64'd0);
    check("abort_buttons2",  64'(bus2.buttons),  64'd0);
    model_prev = '0;
    reset = 1'b0;
    repeat (100) @(posedge clk); #1;
    check("abort_buttons_hold", 64'(bus.buttons), 64'd0);

    // First read after reset compares against zero.
    issue_read(16'h8001, 1'b0, 1'b1);
    wait_drain(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/pad_reader.md
PAD_READER -- requirements
Module: pad_reader

Interface
REQ-001 Parameter NUM_PADS, default 2: number of serial pads read in parallel; legal range 1..4.
REQ-002 Parameter NUM_BITS, default 8: bits shifted per pad per read; legal range 8..16 (8 = NES, 16 = SNES).
REQ-003 Parameter CLK_DIV, default 300: clk cycles per protocol phase; legal minimum 4.
REQ-004 clk  input  1  sole system clock; every flop is clocked on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  enable; start is accepted only while en=1.
REQ-007 start  input  1  read request, sampled in IDLE only.
REQ-008 ser_data  input  NUM_PADS  active-low serial data, one line per pad, asynchronous to clk.
REQ-009 ser_latch  output  1  shared pad latch strobe, active-high.
REQ-010 ser_clk  output  1  shared pad shift clock; idles high.
REQ-011 buttons  output  NUM_PADS*NUM_BITS  active-high button state; bit p*NUM_BITS+i is pad p, serial bit i.
REQ-012 valid  output  1  one-cycle pulse when buttons has been updated.
REQ-013 busy  output  1  high from LATCH through DONE inclusive.

Function
REQ-014 Each ser_data line SHALL pass through a two-flop synchroniser before sampling.
REQ-015 FSM states are IDLE, LATCH, SHIFT_LO, SHIFT_HI and DONE; each of LATCH, SHIFT_LO and SHIFT_HI lasts one phase counted by a divider that is cleared on every state entry.
REQ-016 Transitions:
- IDLE->LATCH when start=1 and en=1.
- LATCH lasts 2 phases with ser_latch=1, ser_clk=1, then ->SHIFT_LO with bit index 0.
- SHIFT_LO lasts 1 phase with ser_clk=0; on its final cycle, synchronised ser_data is sampled into shift bit [index]; then ->SHIFT_HI.
- SHIFT_HI lasts 1 phase with ser_clk=1; then ->SHIFT_LO with index+1, or ->DONE when index=NUM_BITS-1.
- DONE lasts 1 cycle; then ->IDLE.
REQ-017 On the DONE cycle, buttons SHALL be loaded with the inverted samples and valid SHALL be 1; buttons holds its value at all other times.
REQ-018 Latency SHALL be exactly (2+2*NUM_BITS)*CLK_DIV+1 cycles from the start-accept edge to valid=1.
REQ-019 start while busy=1 SHALL be ignored, with no queuing; start held high SHALL give back-to-back reads, with IDLE occupying 1 cycle between reads.
REQ-020 en=0 during a read SHALL NOT abort it; en only gates the IDLE->LATCH transition.
REQ-021 The bit index SHALL be ceil(log2(NUM_BITS)) bits wide and SHALL NOT wrap within a read.
REQ-022 ser_latch and ser_clk SHALL be driven directly from registers, with no combinational glitches.

Reset
REQ-023 reset=1 SHALL force IDLE, clear the divider and index, and set ser_latch=0, ser_clk=1, buttons=0, valid=0 and busy=0 on the next edge.
REQ-024 reset asserted mid-read SHALL abandon the read with no valid pulse and leave buttons at 0.
REQ-025 reset SHALL take priority over start and en.

Configuration
REQ-026 With macro PAD_CHANGE_DETECT_EN defined, an extra output `changed` (width NUM_PADS) SHALL be present:
- changed[p] pulses together with valid when pad p's new NUM_BITS slice differs from its previous slice.
- changed resets to 0.
- The first read after reset compares against 0.
REQ-027 Without PAD_CHANGE_DETECT_EN, the changed port and its comparison logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Settings NUM_PADS=2, NUM_BITS=8, CLK_DIV=4; pad0 drives A=SEL=R pressed (line low), pad1 drives nothing pressed. Required: valid at cycle 73 after the start accept, buttons=16'h0085, ser_latch high for 8 cycles, 8 ser_clk low pulses of 4 cycles each.
REQ-029 Settings NUM_BITS=16, NUM_PADS=1, CLK_DIV=4; all 16 lines driven low. Required: buttons=16'hFFFF, latency 137 cycles.
REQ-030 start held high for 3 reads with a constant pattern. Required: valid pulses spaced 74 cycles apart (NUM_BITS=8, CLK_DIV=4); start pulses issued during busy are ignored.
REQ-031 reset asserted at the 4th SHIFT_LO. Required: next cycle ser_clk=1, ser_latch=0, busy=0, buttons=0, and no valid pulse.
REQ-032 en=0 with start=1. Required: no ser_latch pulse. Setting en=0 mid-read: the read completes and valid fires.
REQ-033 With PAD_CHANGE_DETECT_EN, two identical reads then one with pad1 changed. Required: changed=2'b00 then 2'b10, each pulsed with valid.
